// File: rtl/time_set_ctrl.sv
// Clock-setting controller: MODE/ADJ press codes drive an RUN/SET_HH/SET_MM/SET_SS editor.
// Optional inactivity abort in set mode is built when TIME_SET_TIMEOUT_EN is defined.
module time_set_ctrl #(
  parameter int BLINK_CYC   = 25_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [1:0] mode_st,
  input  logic [1:0] adj_st,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [5:0] cur_ss,
  output logic [4:0] set_hh,
  output logic [5:0] set_mm,
  output logic [5:0] set_ss,
  output logic       load,
  output logic       setting,
  output logic [2:0] blink_mask
);

  typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_t;

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  state_t      state_q, state_d;
  logic [1:0]  mode_prev, adj_prev;
  logic        mode_short, mode_long, adj_short, adj_long;
  logic        mode_ev, adj_ev;
  logic [4:0]  hh_q, hh_d;
  logic [5:0]  mm_q, mm_d, ss_q, ss_d;
  logic        load_q, load_d;
  logic        setting_q;
  logic [BW-1:0] blink_cnt;
  logic        blink_ph;
  logic        blink_restart;
  logic        timeout_hit;

  // An event is a fresh press: previous code idle, current code short or long.
  assign mode_short = (mode_prev == 2'b00) && (mode_st == 2'b01);
  assign mode_long  = (mode_prev == 2'b00) && (mode_st == 2'b10);
  assign adj_short  = (adj_prev == 2'b00) && (adj_st == 2'b01);
  assign adj_long   = (adj_prev == 2'b00) && (adj_st == 2'b10);
  assign mode_ev    = mode_short || mode_long;
  assign adj_ev     = adj_short || adj_long;

`ifdef TIME_SET_TIMEOUT_EN
  localparam logic [28:0] TO_LAST = 29'(TIMEOUT_CYC - 1);
  logic [28:0] to_cnt;

  assign timeout_hit = (state_q != RUN) && !mode_ev && !adj_ev && (to_cnt == TO_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_q == RUN || state_d == RUN || mode_ev || adj_ev) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 29'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    hh_d          = hh_q;
    mm_d          = mm_q;
    ss_d          = ss_q;
    load_d        = 1'b0;
    blink_restart = 1'b0;
    case (state_q)
      RUN: begin
        if (mode_long) begin
          state_d       = SET_HH;
          hh_d          = cur_hh;
          mm_d          = cur_mm;
          ss_d          = cur_ss;
          blink_restart = 1'b1;
        end
      end
      default: begin
        // MODE has priority, so a simultaneous ADJ event is dropped here.
        if (mode_long) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (mode_short) begin
          case (state_q)
            SET_HH:  state_d = SET_MM;
            SET_MM:  state_d = SET_SS;
            default: state_d = SET_HH;
          endcase
        end else if (adj_ev) begin
          blink_restart = 1'b1;
          case (state_q)
            SET_HH: begin
              if (adj_short) hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
              else           hh_d = (hh_q == 5'd0) ? 5'd23 : hh_q - 5'd1;
            end
            SET_MM: begin
              if (adj_short) mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
              else           mm_d = (mm_q == 6'd0) ? 6'd59 : mm_q - 6'd1;
            end
            default: begin
              if (adj_short) ss_d = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
              else           ss_d = (ss_q == 6'd0) ? 6'd59 : ss_q - 6'd1;
            end
          endcase
        end else if (timeout_hit) begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q   <= RUN;
      hh_q      <= '0;
      mm_q      <= '0;
      ss_q      <= '0;
      load_q    <= 1'b0;
      setting_q <= 1'b0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      // Track the live codes during reset so a code held across reset is not a press.
      mode_prev <= mode_st;
      adj_prev  <= adj_st;
    end else begin
      state_q   <= state_d;
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      load_q    <= load_d;
      setting_q <= (state_d != RUN);
      mode_prev <= mode_st;
      adj_prev  <= adj_st;
      if (state_d == RUN || blink_restart) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    blink_mask = 3'b000;
    case (state_q)
      SET_HH:  blink_mask = {blink_ph, 2'b00};
      SET_MM:  blink_mask = {1'b0, blink_ph, 1'b0};
      SET_SS:  blink_mask = {2'b00, blink_ph};
      default: blink_mask = 3'b000;
    endcase
  end

  assign set_hh  = hh_q;
  assign set_mm  = mm_q;
  assign set_ss  = ss_q;
  assign load    = load_q;
  assign setting = setting_q;

endmodule
